popcount_rr_arbiter: RTL and testbench
======================================

Name: popcount_rr_arbiter

Overview:
- Shares one registered population-count datapath among NREQ requesters.
- Round-robin arbitration picks one requester; its WIDTH-bit word is counted, and the result goes back on a single response channel tagged with the requester id.
- Sits between several bit-vector producers (flag/mask generators) and the popcount engine, so the engine does not have to be replicated per producer.

Parameters:
- WIDTH, 32, bits per request word.
- NREQ, 4, number of requesters (>=2).
- CW, $clog2(WIDTH+1), count width; holds the value WIDTH itself (32 -> 6 bits).
- IDW, $clog2(NREQ), requester id width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk, rst=0 resets.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_count  out  CW  number of 1 bits in the granted word.
- rsp_id  out  IDW  index of the requester the response belongs to.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, CNT, RSP.
- Accept window: req_ready may be non-zero only when state==IDLE, or state==RSP && rsp_ready==1.
- Arbitration: combinational round-robin over req_valid, starting at (ptr+1) mod NREQ and wrapping.
  - req_ready is one-hot to the winner, or all-zero if no valid request or the window is closed.
  - Requesters must not derive req_valid from req_ready.
- Handshake: a request is accepted on the edge where req_valid[i] && req_ready[i].
  - That edge captures req_data word i into the operand register and i into the id register.
  - ptr <= i on the same edge; state <= CNT.
- CNT (exactly 1 cycle): the popcount sub-module registers the count of the operand at the end of CNT; state <= RSP.
- RSP: rsp_valid=1; rsp_count and rsp_id are stable until the edge where rsp_ready=1.
  - On that edge: if a new request is accepted in the same cycle, state <= CNT (back-to-back); otherwise state <= IDLE.
- Latency: accept at edge E -> rsp_valid high from E+2. Peak throughput is one response per 2 cycles.
- A requester whose req_valid drops before it is granted is simply skipped; no state is kept per requester.
- A requester that keeps req_valid high is served again only after every other valid requester has been served once (fairness bound: NREQ grants).
- Arithmetic: the count is an unsigned sum of WIDTH single bits, zero-extended to CW. No overflow is possible.
- Reset values: rsp_valid=0, rsp_count=0, rsp_id=0, req_ready=0, busy=0, state=IDLE, ptr=NREQ-1 (requester 0 wins first), operand=0.
- Reset mid-operation (CNT or RSP): the in-flight result is discarded with no response, and the held-off requester must re-request.
- rsp_valid with rsp_ready held low: the response is held indefinitely and no new request is accepted.

Decomposition:
- Package popcount_pkg:
  - state enum {IDLE, CNT, RSP};
  - helper constants CW_OF(w)=$clog2(w+1) and IDW_OF(n)=$clog2(n).
- Sub-module popcount_reg:
  - ports: WIDTH-bit operand in, enable in, CW-bit registered count out.
  - synchronous active-low reset to 0; updates only when enable=1 (enable = state==CNT).
- Round-robin priority logic stays inline in popcount_rr_arbiter.

Test Plan:
- Single request: reset, then req_valid=4'b0001, req_data[0]=32'h0000_0029 -> req_ready=4'b0001 for one cycle; 2 cycles later rsp_valid=1, rsp_count=3, rsp_id=0.
- Boundary words: 32'h0000_0000 -> count 0; 32'hFFFF_FFFF -> count 32 (6'b100000, no truncation); 32'h8000_0001 -> count 2.
- Round-robin fairness: all 4 valid, rsp_ready=1, words 1,3,5,7 bits -> grant order 0,1,2,3,0; responses (id,count) = (0,1),(1,3),(2,5),(3,7), one every 2 cycles.
- Back-pressure: hold rsp_ready=0 for 6 cycles with requests pending -> rsp_valid, rsp_count and rsp_id frozen, req_ready=0 throughout; on rsp_ready=1 the next grant happens in that same cycle.
- Skip/wrap: ptr=2, req_valid=4'b0011 -> grant 0, then 1; then req_valid=4'b1000 only -> grant 3.
- Reset mid-flight: drive rst=0 during CNT -> next cycle rsp_valid=0, busy=0, and requester 0 wins the first grant after rst returns to 1.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount arbiter slice.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CNT,
        RSP
    } state_t;

    // Bits needed to hold the value w itself.
    function automatic int CW_OF(input int w);
        return $clog2(w + 1);
    endfunction

    // Bits needed to index n items.
    function automatic int IDW_OF(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/popcount_reg.sv
// Registered population count of a WIDTH-bit operand, loaded on enable.
module popcount_reg
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = CW_OF(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand,
    input  logic             enable,
    output logic [CW-1:0]    count
);

    logic [CW-1:0] ones;

    // Unsigned sum of the operand bits, zero-extended to CW.
    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(operand[i]);
        end
    end

    // Hold the count except on enabled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (enable) begin
            count <= ones;
        end
    end

endmodule

// File: rtl/popcount_rr_arbiter.sv
// Round-robin arbiter sharing one registered popcount engine among NREQ requesters.
module popcount_rr_arbiter
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int CW    = CW_OF(WIDTH),
    parameter int IDW   = IDW_OF(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CW-1:0]         rsp_count,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [WIDTH-1:0] operand;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_word;
    logic             win_found;
    logic             window;
    logic             accept;
    logic             cnt_en;
    int unsigned      cand;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_word  = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
                win_word  = req_data[cand*WIDTH +: WIDTH];
            end
        end
    end

    // Grant only while the engine can take a new operand.
    always_comb begin
        window    = (state == IDLE) || (state == RSP && rsp_ready);
        req_ready = (window && win_found) ? (NREQ'(1) << win_idx) : '0;
        accept    = window && win_found;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CNT;
            end
            CNT: begin
                cnt_en    = 1'b1;
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = accept ? CNT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer, operand and response id registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= IDW'(NREQ - 1);
            operand <= '0;
            rsp_id  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr     <= win_idx;
                operand <= win_word;
                rsp_id  <= win_idx;
            end
        end
    end

    popcount_reg #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_popcount_reg (
        .clk     (clk),
        .rst     (rst),
        .operand (operand),
        .enable  (cnt_en),
        .count   (rsp_count)
    );

endmodule

// File: tb/tb_popcount_rr_arbiter.sv
// Randomized + directed bench for popcount_rr_arbiter against a transaction-level model.
module tb_popcount_rr_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int CW    = 6;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [CW-1:0]         rsp_count;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    popcount_rr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = counting, 2 = response pending
    int          m_phase = 0;
    int          m_last  = NREQ - 1;
    int          m_count = 0;
    int          m_id    = 0;
    logic [31:0] m_word  = '0;
    int          want_cnt = -1;
    int          glog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*WIDTH-1:0] d, input logic rr);
        int              pick;
        logic            win;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        rst = r; req_valid = v; req_data = d; rsp_ready = rr;
        #1;
        win     = (m_phase == 0) || (m_phase == 2 && rr);
        pick    = rr_pick(m_last, v);
        exp_rdy = (win && pick >= 0) ? (NREQ'(1) << pick) : '0;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_phase == 2);
        check("busy", busy, m_phase != 0);
        check("rsp_count", rsp_count, m_count);
        check("rsp_id", rsp_id, m_id);
        if (want_cnt >= 0) check("dir_cnt", rsp_count, want_cnt);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
        @(posedge clk);
        if (!r) begin
            m_phase = 0; m_last = NREQ - 1; m_count = 0; m_id = 0;
        end else begin
            if (m_phase == 1) begin
                m_count = $countones(m_word);
                m_phase = 2;
            end else if (m_phase == 0 || (m_phase == 2 && rr)) begin
                m_phase = 0;
                if (exp_rdy != 0) begin
                    m_phase = 1;
                    m_last  = pick;
                    m_id    = pick;
                    m_word  = d[pick*WIDTH +: WIDTH];
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic single(input logic [31:0] w, input int exp_cnt);
        logic [NREQ*WIDTH-1:0] d;
        d = '0;
        d[31:0] = w;
        step(1'b1, 4'b0001, d, 1'b1);
        step(1'b1, 4'b0000, d, 1'b1);
        want_cnt = exp_cnt;
        step(1'b1, 4'b0000, d, 1'b1);
        want_cnt = -1;
    endtask

    function automatic logic [NREQ*WIDTH-1:0] rand_data();
        logic [NREQ*WIDTH-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 7))
                0:       d[i*WIDTH +: WIDTH] = '0;
                1:       d[i*WIDTH +: WIDTH] = '1;
                default: d[i*WIDTH +: WIDTH] = $urandom;
            endcase
        end
        return d;
    endfunction

    int fair_exp[5] = '{0, 1, 2, 3, 0};
    int wrap_exp[3] = '{0, 1, 3};

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and single-request latency
        single(32'h0000_0029, 3);
        single(32'h0000_0000, 0);
        single(32'hFFFF_FFFF, 32);
        single(32'h8000_0001, 2);

        // Fairness: all requesters valid, always-ready consumer
        do_reset();
        d = {32'h0000_007F, 32'h0000_001F, 32'h0000_0007, 32'h0000_0001};
        glog.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, d, 1'b1);
        check("fair_n", glog.size(), 5);
        for (int i = 0; i < 5; i++) check("fair_ord", (i < glog.size()) ? glog[i] : 99, fair_exp[i]);

        // Back-pressure: response frozen, no grants, then same-cycle regrant
        do_reset();
        d = rand_data();
        step(1'b1, 4'b1111, d, 1'b1);
        step(1'b1, 4'b1111, d, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, rand_data(), 1'b0);
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        step(1'b1, 4'b0000, d, 1'b1);
        step(1'b1, 4'b0000, d, 1'b1);

        // Skip and wrap from ptr=2
        do_reset();
        d = rand_data();
        step(1'b1, 4'b0100, d, 1'b1);
        step(1'b1, 4'b0000, d, 1'b1);
        step(1'b1, 4'b0000, d, 1'b1);
        glog.delete();
        step(1'b1, 4'b0011, d, 1'b1);
        step(1'b1, 4'b0011, d, 1'b1);
        step(1'b1, 4'b0011, d, 1'b1);
        step(1'b1, 4'b0011, d, 1'b1);
        step(1'b1, 4'b1000, d, 1'b1);
        check("wrap_n", glog.size(), 3);
        for (int i = 0; i < 3; i++) check("wrap_ord", (i < glog.size()) ? glog[i] : 99, wrap_exp[i]);

        // Reset during CNT discards the result; requester 0 wins next
        do_reset();
        step(1'b1, 4'b0010, rand_data(), 1'b1);
        step(1'b1, 4'b0000, rand_data(), 1'b1);
        step(1'b1, 4'b0000, rand_data(), 1'b1);
        step(1'b1, 4'b0100, rand_data(), 1'b1);
        step(1'b0, 4'b0000, rand_data(), 1'b1);
        glog.delete();
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        check("rst_first", (glog.size() > 0) ? glog[0] : 99, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 NREQ'($urandom),
                 rand_data(),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
